// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, MODE codes and FSM state encodings.
package timer_dev_pkg;

  // Word offsets inside the 16-byte window (addr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_UNMAP  = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // MODE codes; 10/11 fall back to one-shot behaviour
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// CPU data-bus responder interface: the memory stage drives address, write
// strobe, byte lanes and data; the timer returns combinational read data.
interface timer_dev_if;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output byteen, output wdata, input rdata);
  modport slave  (input addr, input we, input byteen, input wdata, output rdata);
endinterface

// File: rtl/timer_dev.sv
// Countdown timer with CTRL/PRESET/COUNT registers, a four-state countdown
// FSM and a maskable level interrupt.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_fsm;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q;
  logic              if_q;
  state_t            state_q;

  logic        hit;
  logic [1:0]  off;
  logic        wr_ctrl, wr_preset;
  logic        reload;
  logic [31:0] ctrl_merged;
  logic        unused_addr_lsb;

  // Merge enabled byte lanes of new data into the old register value
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  assign hit             = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off             = bus.addr[3:2];
  assign unused_addr_lsb = ^bus.addr[1:0];
  assign wr_ctrl         = bus.we & hit & (off == OFF_CTRL);
  assign wr_preset       = bus.we & hit & (off == OFF_PRESET);
  assign reload          = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign irq             = if_q & ctrl_q[CTRL_IM];

  // Combinational read mux; misses and the unmapped slot return zero
  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      case (off)
        OFF_CTRL:   bus.rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
        OFF_PRESET: bus.rdata = preset_q;
        OFF_COUNT:  bus.rdata = count_q;
        default:    bus.rdata = 32'd0;
      endcase
    end
  end

  // Next CTRL/PRESET: FSM clears EN after a one-shot, then bus lanes override it
  always_comb begin
    ctrl_fsm = ctrl_q;
    if (state_q == ST_INT && !reload)
      ctrl_fsm[CTRL_EN] = 1'b0;
    ctrl_merged = merge_lanes({{(32-CTRL_W){1'b0}}, ctrl_fsm}, bus.wdata, bus.byteen);
    ctrl_d      = wr_ctrl ? ctrl_merged[CTRL_W-1:0] : ctrl_fsm;
    preset_d    = wr_preset ? merge_lanes(preset_q, bus.wdata, bus.byteen) : preset_q;
  end

  // Register file update
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  // Countdown FSM with COUNT and interrupt flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      if_q    <= 1'b0;
    end else begin
      // Any CTRL/PRESET write acknowledges a held one-shot flag
      if (wr_ctrl || wr_preset)
        if_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_q[CTRL_EN])
            state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_q[CTRL_EN]) begin
            state_q <= ST_IDLE;
          end else if (count_q > 32'd1) begin
            count_q <= count_q - 32'd1;
          end else begin
            count_q <= '0;
            state_q <= ST_INT;
            if_q    <= 1'b1;
          end
        end
        ST_INT: begin
          // Auto-reload flag is a single-cycle pulse
          if (reload)
            if_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
